// File: rtl/ff_bank_scan_reader_if.sv
// Observation-port bus between the flip-flop lab mux and the scan reader.
// The master side drives requests and the mux T line; the slave side is the reader.
interface ff_bank_scan_reader_if #(
    parameter int FRAME_CNT_W = 8
);
    logic                   start;
    logic                   continuous;
    logic                   t_in;
    logic [1:0]             sel;
    logic [3:0]             snap;
    logic                   snap_valid;
    logic                   snap_changed;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output start, continuous, t_in,
        input  sel, snap, snap_valid, snap_changed, busy, frame_count
    );

    modport slave (
        input  start, continuous, t_in,
        output sel, snap, snap_valid, snap_changed, busy, frame_count
    );
endinterface

// File: rtl/ff_bank_scan_reader.sv
// Steps the 4:1 mux select through channels 0..3, lets each settle, samples T,
// and publishes the assembled 4-bit snapshot with valid/changed pulses and a frame count.
module ff_bank_scan_reader #(
    parameter int SETTLE      = 1,
    parameter int FRAME_CNT_W = 8
) (
    input logic                    clk,
    input logic                    s_reset,
    ff_bank_scan_reader_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t                 state_q, state_d;
    logic [1:0]             ch_q, ch_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             sel_q, sel_d;
    logic [3:0]             shadow_q, shadow_d;
    logic [3:0]             snap_q, snap_d;
    logic                   snap_valid_q, snap_valid_d;
    logic                   snap_changed_q, snap_changed_d;
    logic                   busy_q, busy_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [3:0]             frame_w;

    // Channel 3 is taken straight from t_in so the frame closes on the same edge.
    assign frame_w = {bus.t_in, shadow_q[2:0]};

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        shadow_d       = shadow_q;
        snap_d         = snap_q;
        snap_valid_d   = 1'b0;
        snap_changed_d = 1'b0;
        busy_d         = busy_q;
        frame_count_d  = frame_count_q;

        case (state_q)
            S_IDLE: begin
                sel_d = 2'b00;
                if (bus.start) begin
                    state_d = S_SETTLE;
                    ch_d    = 2'b00;
                    cnt_d   = SETTLE_CNT;
                    busy_d  = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                shadow_d[ch_q] = bus.t_in;
                if (ch_q != 2'd3) begin
                    ch_d    = ch_q + 2'd1;
                    sel_d   = ch_q + 2'd1;
                    cnt_d   = SETTLE_CNT;
                    state_d = S_SETTLE;
                end else begin
                    snap_d         = frame_w;
                    snap_valid_d   = 1'b1;
                    snap_changed_d = (frame_w != snap_q);
                    frame_count_d  = frame_count_q + 1'b1;
                    ch_d           = 2'b00;
                    sel_d          = 2'b00;
                    if (bus.continuous) begin
                        cnt_d   = SETTLE_CNT;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q        <= S_IDLE;
            ch_q           <= 2'b00;
            cnt_q          <= 4'd0;
            sel_q          <= 2'b00;
            shadow_q       <= 4'b0000;
            snap_q         <= 4'b0000;
            snap_valid_q   <= 1'b0;
            snap_changed_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            shadow_q       <= shadow_d;
            snap_q         <= snap_d;
            snap_valid_q   <= snap_valid_d;
            snap_changed_q <= snap_changed_d;
            busy_q         <= busy_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign bus.sel          = sel_q;
    assign bus.snap         = snap_q;
    assign bus.snap_valid   = snap_valid_q;
    assign bus.snap_changed = snap_changed_q;
    assign bus.busy         = busy_q;
    assign bus.frame_count  = frame_count_q;
endmodule

// File: tb/tb_ff_bank_scan_reader.sv
// Directed bench for the scan reader: three instances cover SETTLE=1, SETTLE=3
// and a 2-bit frame counter; the mux is modelled as t_in = pattern[sel].
module tb_ff_bank_scan_reader;
    logic clk;
    logic s_reset;
    int   checks;
    int   errors;
    int   pulses;
    int   busy_hi;

    logic [3:0] pat1;
    logic [3:0] pat3;
    logic [3:0] patw;
    logic       glitch3;
    logic [1:0] wexp [5];

    ff_bank_scan_reader_if #(.FRAME_CNT_W(8)) bus1 ();
    ff_bank_scan_reader_if #(.FRAME_CNT_W(8)) bus3 ();
    ff_bank_scan_reader_if #(.FRAME_CNT_W(2)) busw ();

    ff_bank_scan_reader #(.SETTLE(1), .FRAME_CNT_W(8)) dut1 (
        .clk(clk), .s_reset(s_reset), .bus(bus1)
    );
    ff_bank_scan_reader #(.SETTLE(3), .FRAME_CNT_W(8)) dut3 (
        .clk(clk), .s_reset(s_reset), .bus(bus3)
    );
    ff_bank_scan_reader #(.SETTLE(1), .FRAME_CNT_W(2)) dutw (
        .clk(clk), .s_reset(s_reset), .bus(busw)
    );

    assign bus1.t_in = pat1[bus1.sel];
    assign bus3.t_in = pat3[bus3.sel] ^ glitch3;
    assign busw.t_in = patw[busw.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        s_reset = 1'b1;
        bus1.start = 1'b0; bus1.continuous = 1'b0;
        bus3.start = 1'b0; bus3.continuous = 1'b0;
        busw.start = 1'b0; busw.continuous = 1'b0;
        pat1 = 4'b1010; pat3 = 4'b0110; patw = 4'b0011; glitch3 = 1'b0;
        wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;

        // Reset and idle
        tick(); tick();
        s_reset = 1'b0;
        chk("rst_sel", bus1.sel, 0);
        chk("rst_snap", bus1.snap, 0);
        chk("rst_valid", bus1.snap_valid, 0);
        chk("rst_changed", bus1.snap_changed, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_fc", bus1.frame_count, 0);
        pulses = 0; busy_hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            pulses += int'(bus1.snap_valid);
            busy_hi += int'(bus1.busy);
        end
        chk("idle_valid_cnt", pulses, 0);
        chk("idle_busy_cnt", busy_hi, 0);
        chk("idle_sel", bus1.sel, 0);

        // Single frame, pattern 1010
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("f1_sel_c%0d", c), bus1.sel, c / 2);
            chk($sformatf("f1_valid_c%0d", c), bus1.snap_valid, 0);
            chk($sformatf("f1_busy_c%0d", c), bus1.busy, 1);
            tick();
        end
        chk("f1_valid", bus1.snap_valid, 1);
        chk("f1_snap", bus1.snap, 4'b1010);
        chk("f1_changed", bus1.snap_changed, 1);
        chk("f1_fc", bus1.frame_count, 1);
        chk("f1_busy_end", bus1.busy, 0);
        chk("f1_sel_end", bus1.sel, 0);
        tick();
        chk("f1_valid_pulse", bus1.snap_valid, 0);
        chk("f1_changed_pulse", bus1.snap_changed, 0);
        chk("f1_snap_hold", bus1.snap, 4'b1010);

        // Repeat frame with a stray start while busy
        bus1.start = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            bus1.start = (c == 3);
            tick();
        end
        bus1.start = 1'b0;
        chk("f2_valid", bus1.snap_valid, 1);
        chk("f2_snap", bus1.snap, 4'b1010);
        chk("f2_changed", bus1.snap_changed, 0);
        chk("f2_fc", bus1.frame_count, 2);
        tick();
        chk("f2_no_queue_busy", bus1.busy, 0);
        tick();
        chk("f2_no_queue_busy2", bus1.busy, 0);

        // Continuous, SETTLE=3; glitches on t_in outside the sample cycle
        bus3.continuous = 1'b1;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            glitch3 = ((c % 4) != 3);
            if (c > 0) pulses += int'(bus3.snap_valid);
            tick();
        end
        glitch3 = 1'b0;
        chk("c1_valid", bus3.snap_valid, 1);
        chk("c1_snap", bus3.snap, 4'b0110);
        chk("c1_changed", bus3.snap_changed, 1);
        chk("c1_fc", bus3.frame_count, 1);
        chk("c1_busy", bus3.busy, 1);
        pat3 = 4'b1001;
        for (int c = 16; c < 32; c++) begin
            if (c > 16) pulses += int'(bus3.snap_valid);
            tick();
        end
        chk("c2_valid", bus3.snap_valid, 1);
        chk("c2_snap", bus3.snap, 4'b1001);
        chk("c2_changed", bus3.snap_changed, 1);
        chk("c2_fc", bus3.frame_count, 2);
        for (int c = 32; c < 48; c++) begin
            if (c == 40) bus3.continuous = 1'b0;
            if (c > 32) pulses += int'(bus3.snap_valid);
            tick();
        end
        chk("c_gap_pulses", pulses, 0);
        chk("c3_valid", bus3.snap_valid, 1);
        chk("c3_snap", bus3.snap, 4'b1001);
        chk("c3_changed", bus3.snap_changed, 0);
        chk("c3_fc", bus3.frame_count, 3);
        chk("c3_busy", bus3.busy, 0);
        tick();
        chk("c3_idle_valid", bus3.snap_valid, 0);
        chk("c3_idle_busy", bus3.busy, 0);
        chk("c3_idle_sel", bus3.sel, 0);

        // Frame counter wrap with FRAME_CNT_W=2
        for (int f = 0; f < 5; f++) begin
            busw.start = 1'b1;
            tick();
            busw.start = 1'b0;
            repeat (8) tick();
            chk($sformatf("w%0d_valid", f), busw.snap_valid, 1);
            chk($sformatf("w%0d_fc", f), busw.frame_count, wexp[f]);
            chk($sformatf("w%0d_changed", f), busw.snap_changed, (f == 0) ? 1 : 0);
        end
        tick();

        // Reset mid-frame, extra starts ignored
        bus1.start = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            bus1.start = (c == 1) || (c == 2);
            tick();
        end
        bus1.start = 1'b0;
        chk("mr_busy_before", bus1.busy, 1);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        chk("mr_sel", bus1.sel, 0);
        chk("mr_snap", bus1.snap, 0);
        chk("mr_fc", bus1.frame_count, 0);
        chk("mr_busy", bus1.busy, 0);
        chk("mr_valid", bus1.snap_valid, 0);
        pulses = 0; busy_hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            pulses += int'(bus1.snap_valid);
            busy_hi += int'(bus1.busy);
        end
        chk("mr_valid_cnt", pulses, 0);
        chk("mr_busy_cnt", busy_hi, 0);
        chk("mr_snap_hold", bus1.snap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
